sodor5_instr_sequencer: RTL

//   Sequences the instruction stream into the sodor5 core's imem response port for directed and random runs.

---
 rtl/sodor5_tb_pkg.sv | 30 +++
 rtl/sodor5_instr_encoder.sv | 62 ++++++
 rtl/sodor5_instr_sequencer.sv | 107 ++++++++++
 3 files changed

// File: rtl/sodor5_tb_pkg.sv
// Shared constants and types for the sodor5 instruction sequencer: opcodes,
// LFSR taps, instruction-class and sequencer-state encodings.
package sodor5_tb_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;

  typedef enum logic [1:0] {
    CLS_RTYPE = 2'd0,
    CLS_ITYPE = 2'd1,
    CLS_LOAD  = 2'd2
  } instr_cls_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WARMUP = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } seq_state_t;

  // Right-shifting Galois step: the shifted-out bit folds the taps back in.
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ LFSR_TAPS) : (l >> 1);
  endfunction

endpackage

// File: rtl/sodor5_instr_encoder.sv
// Combinational mapping from an LFSR value and class mask to one RV32I
// instruction word (R-type, I-type ALU or word-aligned byte load).
module sodor5_instr_encoder
  import sodor5_tb_pkg::*;
(
  input  logic [31:0] lfsr,
  input  logic [2:0]  class_mask,
  output logic [31:0] instr
);

  logic [2:0]  mask_eff;
  instr_cls_t  cls_raw;
  instr_cls_t  cls;
  logic        cls_enabled;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] imm;
  logic        unused_bits;

  assign rd          = lfsr[11:7];
  assign funct3      = lfsr[14:12];
  assign rs1         = lfsr[19:15];
  assign rs2         = lfsr[24:20];
  assign unused_bits = ^lfsr[6:2];

  always_comb begin
    mask_eff = (class_mask == 3'b000) ? 3'b001 : class_mask;

    case (lfsr[1:0])
      2'd1:    cls_raw = CLS_ITYPE;
      2'd2:    cls_raw = CLS_LOAD;
      default: cls_raw = CLS_RTYPE;
    endcase

    if (cls_raw == CLS_RTYPE)      cls_enabled = mask_eff[0];
    else if (cls_raw == CLS_ITYPE) cls_enabled = mask_eff[1];
    else                           cls_enabled = mask_eff[2];

    // A disabled class falls back to the first enabled one, rtype first.
    if (cls_enabled)      cls = cls_raw;
    else if (mask_eff[0]) cls = CLS_RTYPE;
    else if (mask_eff[1]) cls = CLS_ITYPE;
    else                  cls = CLS_LOAD;

    funct7 = 7'h00;
    if (((funct3 == 3'd0) || (funct3 == 3'd5)) && lfsr[30]) funct7 = 7'h20;

    imm = lfsr[31:20];
    if (funct3 == 3'd1)      imm = imm & 12'h01F;
    else if (funct3 == 3'd5) imm = imm & 12'h41F;

    case (cls)
      CLS_ITYPE: instr = {imm, rs1, funct3, rd, OPC_OP_IMM};
      CLS_LOAD:  instr = {lfsr[31:20] & 12'h03C, 5'd0, lfsr[14], 2'b00, rd, OPC_LOAD};
      default:   instr = {funct7, rs2, rs1, funct3, rd, OPC_OP};
    endcase
  end

endmodule

// File: rtl/sodor5_instr_sequencer.sv
// Feeds the sodor5 imem response port: warm-up NOPs, LFSR-generated RV32I
// instructions, then drain NOPs, over a valid/ready handshake.
module sodor5_instr_sequencer
  import sodor5_tb_pkg::*;
#(
  parameter int unsigned NUM_INSTRS  = 64,
  parameter int unsigned WARMUP_NOPS = 4,
  parameter int unsigned DRAIN_NOPS  = 5,
  parameter logic [31:0] SEED        = 32'h0000_0362,
  parameter logic [2:0]  CLASS_MASK  = 3'b001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic        busy,
  output logic        done,
  output logic [15:0] issued_count
);

  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [2:0]  MASK_EFF = (CLASS_MASK == 3'b000) ? 3'b001 : CLASS_MASK;

  seq_state_t  state, state_d;
  logic [31:0] cnt, cnt_d;
  logic [31:0] lfsr, lfsr_d;
  logic [15:0] issued_d;
  logic [31:0] enc_word;
  logic        xfer;

  // First non-empty phase following s; empty phases are skipped outright.
  function automatic seq_state_t next_phase(input seq_state_t s);
    seq_state_t nxt;
    nxt = DONE;
    if ((s inside {IDLE, DONE, WARMUP, RUN}) && (DRAIN_NOPS != 0)) nxt = DRAIN;
    if ((s inside {IDLE, DONE, WARMUP}) && (NUM_INSTRS != 0))     nxt = RUN;
    if ((s inside {IDLE, DONE}) && (WARMUP_NOPS != 0))            nxt = WARMUP;
    return nxt;
  endfunction

  function automatic logic [31:0] phase_len(input seq_state_t s);
    case (s)
      WARMUP:  return WARMUP_NOPS;
      RUN:     return NUM_INSTRS;
      DRAIN:   return DRAIN_NOPS;
      default: return 32'd0;
    endcase
  endfunction

  // Encoding the next LFSR value lets the registered word track the handshake.
  sodor5_instr_encoder u_encoder (
    .lfsr       (lfsr_d),
    .class_mask (MASK_EFF),
    .instr      (enc_word)
  );

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    lfsr_d   = lfsr;
    issued_d = issued_count;
    xfer     = instr_valid && instr_ready;

    if ((state == IDLE || state == DONE) && start) begin
      state_d  = next_phase(state);
      cnt_d    = 32'd0;
      lfsr_d   = SEED_EFF;
      issued_d = 16'd0;
    end else if (xfer) begin
      if (state == RUN) begin
        lfsr_d = lfsr_step(lfsr);
        if (issued_count != 16'hFFFF) issued_d = issued_count + 16'd1;
      end
      if (cnt + 32'd1 == phase_len(state)) begin
        state_d = next_phase(state);
        cnt_d   = 32'd0;
      end else begin
        cnt_d = cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 32'd0;
      lfsr         <= SEED_EFF;
      instr_valid  <= 1'b0;
      instr        <= NOP_INSTR;
      busy         <= 1'b0;
      done         <= 1'b0;
      issued_count <= 16'd0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      lfsr         <= lfsr_d;
      instr_valid  <= state_d inside {WARMUP, RUN, DRAIN};
      instr        <= (state_d == RUN) ? enc_word : NOP_INSTR;
      busy         <= state_d inside {WARMUP, RUN, DRAIN};
      done         <= (state_d == DONE);
      issued_count <= issued_d;
    end
  end

endmodule
